// File: rtl/bus_map_pkg.sv
// rtl/bus_map_pkg.sv - data-bus address map, slave/state enums and slave timing helper
package bus_map_pkg;

  localparam logic [31:0] DMEM_BASE  = 32'h1000_0000;
  localparam logic [31:0] DMEM_MASK  = 32'hFFFF_0000;
  localparam logic [31:0] TBMAN_BASE = 32'hFFFF_F000;
  localparam logic [31:0] GPIO_BASE  = 32'hFFFF_2000;
  localparam logic [31:0] TIMER_BASE = 32'hFFFF_8000;
  localparam logic [31:0] UART_BASE  = 32'hFFFF_0000;
  localparam logic [31:0] PERIPH_MASK = 32'hFFFF_F000;

  typedef enum logic [2:0] {
    SL_NONE,
    SL_TBMAN,
    SL_DMEM,
    SL_GPIO,
    SL_TIMER,
    SL_UART
  } slave_e;

  typedef enum logic {
    ST_IDLE,
    ST_WAIT
  } state_e;

  // Slaves that need wait states inserted before their read data is ready.
  function automatic logic is_slow(slave_e s);
    return (s == SL_TIMER) || (s == SL_UART);
  endfunction

endpackage

// File: rtl/addr_region_decode.sv
// rtl/addr_region_decode.sv - priority address-to-slave decoder, shared by data and instruction buses
module addr_region_decode
  import bus_map_pkg::*;
(
  input  logic [31:0] addr,
  output slave_e      slave
);

  always_comb begin
    slave = SL_NONE;
    if      ((addr & PERIPH_MASK) == TBMAN_BASE) slave = SL_TBMAN;
    else if ((addr & DMEM_MASK)   == DMEM_BASE)  slave = SL_DMEM;
    else if ((addr & PERIPH_MASK) == GPIO_BASE)  slave = SL_GPIO;
    else if ((addr & PERIPH_MASK) == TIMER_BASE) slave = SL_TIMER;
    else if ((addr & PERIPH_MASK) == UART_BASE)  slave = SL_UART;
  end

endmodule

// File: rtl/mem_bus_ctrl.sv
// rtl/mem_bus_ctrl.sv - memory-stage bus controller: chip selects, wait states, registered response selects
module mem_bus_ctrl
  import bus_map_pkg::*;
#(
  parameter int unsigned SLOW_WAIT = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] addr,
  output logic        stall,
  output logic        cs_dmem_n,
  output logic        cs_tbman_n,
  output logic        cs_gpio_n,
  output logic        cs_timer_n,
  output logic        cs_uart_n,
  output logic        rsel_dmem_n,
  output logic        rsel_tbman_n,
  output logic        rsel_gpio_n,
  output logic        rsel_timer_n,
  output logic        rsel_uart_n,
  output logic        rvalid,
  output logic        bus_err
);

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  slave_e     slave_q, slave_d;
  logic       we_q, we_d;
  slave_e     rsel_q, rsel_d;
  logic       rvalid_q, rvalid_d;
  logic       bus_err_q, bus_err_d;

  slave_e dec_slave;
  slave_e cs_sel;
  logic   stall_c;

  addr_region_decode u_decode (
    .addr  (addr),
    .slave (dec_slave)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    slave_d   = slave_q;
    we_d      = we_q;
    rsel_d    = SL_NONE;
    rvalid_d  = 1'b0;
    bus_err_d = 1'b0;
    cs_sel    = SL_NONE;
    stall_c   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req) begin
          cs_sel = dec_slave;
          if (dec_slave == SL_NONE) begin
            // Unmapped reads still complete so the mux can return zero.
            bus_err_d = 1'b1;
            rvalid_d  = !we;
          end else if (is_slow(dec_slave) && (SLOW_WAIT != 0)) begin
            stall_c = 1'b1;
            cnt_d   = 4'(SLOW_WAIT - 1);
            slave_d = dec_slave;
            we_d    = we;
            state_d = ST_WAIT;
          end else if (!we) begin
            rsel_d   = dec_slave;
            rvalid_d = 1'b1;
          end
        end
      end
      ST_WAIT: begin
        if (!req) begin
          state_d = ST_IDLE;
        end else begin
          // Decode latched at entry; addr/we may wander while stalled.
          cs_sel = slave_q;
          if (cnt_q != 4'd0) begin
            stall_c = 1'b1;
            cnt_d   = cnt_q - 4'd1;
          end else begin
            state_d = ST_IDLE;
            if (!we_q) begin
              rsel_d   = slave_q;
              rvalid_d = 1'b1;
            end
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= 4'd0;
      slave_q   <= SL_NONE;
      we_q      <= 1'b0;
      rsel_q    <= SL_NONE;
      rvalid_q  <= 1'b0;
      bus_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      slave_q   <= slave_d;
      we_q      <= we_d;
      rsel_q    <= rsel_d;
      rvalid_q  <= rvalid_d;
      bus_err_q <= bus_err_d;
    end
  end

  assign stall      = rst_n && stall_c;
  assign cs_dmem_n  = !(rst_n && (cs_sel == SL_DMEM));
  assign cs_tbman_n = !(rst_n && (cs_sel == SL_TBMAN));
  assign cs_gpio_n  = !(rst_n && (cs_sel == SL_GPIO));
  assign cs_timer_n = !(rst_n && (cs_sel == SL_TIMER));
  assign cs_uart_n  = !(rst_n && (cs_sel == SL_UART));

  assign rsel_dmem_n  = (rsel_q != SL_DMEM);
  assign rsel_tbman_n = (rsel_q != SL_TBMAN);
  assign rsel_gpio_n  = (rsel_q != SL_GPIO);
  assign rsel_timer_n = (rsel_q != SL_TIMER);
  assign rsel_uart_n  = (rsel_q != SL_UART);
  assign rvalid       = rvalid_q;
  assign bus_err      = bus_err_q;

endmodule

// File: doc/mem_bus_ctrl.md
Name: mem_bus_ctrl

Overview:
- Memory-stage bus controller that sits directly upstream of the read-data mux.
- Decodes the data-access address into one active-low chip select per slave (DMEM, TBMAN, GPIO, TIMER, UART).
- Inserts wait states for slow slaves and stalls the pipeline while it does so.
- Produces registered response-phase selects, aligned with synchronous slave read data, that drive the read-data mux's cs_*_n inputs.

Parameters:
DMEM_BASE, 32'h1000_0000, DMEM region base
DMEM_MASK, 32'hFFFF_0000, DMEM region mask (64 KB)
TBMAN_BASE, 32'hFFFF_F000, testbench-manager base (4 KB, mask 32'hFFFF_F000)
GPIO_BASE, 32'hFFFF_2000, GPIO base (4 KB)
TIMER_BASE, 32'hFFFF_8000, timer base (4 KB)
UART_BASE, 32'hFFFF_0000, UART base (4 KB)
SLOW_WAIT, 2, extra wait cycles for TIMER/UART accesses (0..15)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
req  in  1  memory-stage access valid
we  in  1  1 = write, 0 = read
addr  in  32  byte address of access
stall  out  1  hold memory stage; requester keeps req/we/addr stable while high
cs_dmem_n, cs_tbman_n, cs_gpio_n, cs_timer_n, cs_uart_n  out  1 each  access-phase chip selects to slaves (combinational)
rsel_dmem_n, rsel_tbman_n, rsel_gpio_n, rsel_timer_n, rsel_uart_n  out  1 each  registered response-phase selects to read-data mux
rvalid  out  1  read data valid at mux output this cycle
bus_err  out  1  one-cycle pulse: previous access was unmapped

Behaviour:
- Interface: single clock clk; reset rst_n is asynchronous, active-low.
- Decode: hit = ((addr & MASK) == BASE); 4 KB regions use mask 32'hFFFF_F000.
  - Overlap priority: TBMAN > DMEM > GPIO > TIMER > UART.
  - At most one cs_*_n is low in any cycle; same one-hot-or-none rule for rsel_*_n.
- Reset values: state IDLE, wait counter 0, all rsel_*_n = 1, rvalid = 0, bus_err = 0.
  - While rst_n = 0, cs_*_n are forced to 1 and stall to 0 regardless of req.
- FSM states: IDLE, WAIT.
- IDLE, req = 1, fast slave (DMEM/TBMAN/GPIO), or slow slave with SLOW_WAIT = 0:
  - Matching cs low in the same cycle; stall = 0.
  - Read: at the clock edge, matching rsel low and rvalid = 1 for exactly one cycle (read latency 1).
  - Write: no rsel, no rvalid.
- IDLE, req = 1, slow slave with SLOW_WAIT > 0:
  - cs low and stall = 1 in the same cycle.
  - Load counter with SLOW_WAIT-1; go to WAIT.
- WAIT:
  - cs held low every cycle; stall = 1 while counter != 0; counter decrements each cycle.
  - Counter == 0: stall = 0 (final access cycle); on the edge, rsel/rvalid registered as for fast reads; return to IDLE.
  - Total cs-low cycles = SLOW_WAIT+1; stall-high cycles = SLOW_WAIT.
- Unmapped address with req = 1:
  - No cs, stall = 0.
  - Next cycle: bus_err = 1 for one cycle; all rsel high.
  - Read: rvalid = 1, so the mux returns 32'd0.
- req = 0 in IDLE: no cs; next cycle all rsel high, rvalid = 0, bus_err = 0.
- Back-to-back accesses: a new request in the cycle after a response is accepted with no bubble; rsel of the previous read and cs of the new access coexist.
- req dropping in WAIT is a protocol violation:
  - Abort to IDLE the same cycle; cs deasserted; no rvalid, no bus_err.
- Reset mid-WAIT: immediate return to reset values; the pending read produces no response.
- Counter width: 4 bits.
- Addr/we changes while stall = 1 are ignored; the decode latched at entry to WAIT is used.

Decomposition:
- Package bus_map_pkg:
  - Region base/mask localparams.
  - slave_e enum {SL_NONE, SL_TBMAN, SL_DMEM, SL_GPIO, SL_TIMER, SL_UART}.
  - State enum {ST_IDLE, ST_WAIT}.
  - Function is_slow(slave_e).
- Sub-module addr_region_decode: purely combinational addr → slave_e with priority.
  - Reused later by the instruction-side bus.
- mem_bus_ctrl holds the FSM, wait counter, and response registers.

Test Plan:
- Reset: hold rst_n = 0 with req = 1, addr = 32'h1000_0004 → all cs_*_n = 1, all rsel_*_n = 1, stall = 0, rvalid = 0. Release reset → first access decodes normally.
- Fast read: req = 1, we = 0, addr = 32'h1000_0010 → cs_dmem_n = 0 in cycle 0, stall = 0; cycle 1: rsel_dmem_n = 0, rvalid = 1; cycle 2: rsel_dmem_n = 1.
- Slow read, SLOW_WAIT = 2: addr = 32'hFFFF_0004 → cs_uart_n low cycles 0–2; stall = 1 in cycles 0–1, 0 in cycle 2; cycle 3: rsel_uart_n = 0, rvalid = 1.
- Unmapped read: addr = 32'h2000_0000 → no cs, stall = 0; next cycle bus_err = 1, rvalid = 1, all rsel high.
- Back-to-back: DMEM write to 0x1000_0000, then GPIO read 0xFFFF_2008, then TIMER read 0xFFFF_8000 → cs order dmem, gpio, timer; one rvalid for the GPIO read, one for the timer read; never two cs low at once.
- Abort/reset: start a timer read, drop req in cycle 1 → cs high in cycle 1, no rvalid. Repeat with rst_n low in cycle 1 → same, and state returns to IDLE.
